// File: rtl/branch_resolve_ctrl_pkg.sv
// rtl/branch_resolve_ctrl_pkg.sv - shared types and width defaults for branch resolution
package branch_resolve_ctrl_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int PC_W_DEF   = 64;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_B     = 3'd1,
    BR_CBZ   = 3'd2,
    BR_CBNZ  = 3'd3,
    BR_BCOND = 3'd4
  } br_type_t;

  typedef enum logic [3:0] {
    C_EQ = 4'b0000, C_NE = 4'b0001, C_HS = 4'b0010, C_LO = 4'b0011,
    C_MI = 4'b0100, C_PL = 4'b0101, C_VS = 4'b0110, C_VC = 4'b0111,
    C_HI = 4'b1000, C_LS = 4'b1001, C_GE = 4'b1010, C_LT = 4'b1011,
    C_GT = 4'b1100, C_LE = 4'b1101, C_AL = 4'b1110, C_NV = 4'b1111
  } cond_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } brc_state_t;

endpackage

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// rtl/branch_resolve_ctrl_cond_eval.sv - combinational ARM condition-code evaluation against NZCV
module cond_eval
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       true
);

  logic n, z, c, v;

  assign {n, z, c, v} = nzcv;

  always_comb begin
    true = 1'b1;
    case (cond_t'(cond))
      C_EQ:    true = z;
      C_NE:    true = !z;
      C_HS:    true = c;
      C_LO:    true = !c;
      C_MI:    true = n;
      C_PL:    true = !n;
      C_VS:    true = v;
      C_VC:    true = !v;
      C_HI:    true = c && !z;
      C_LS:    true = !c || z;
      C_GE:    true = (n == v);
      C_LT:    true = (n != v);
      C_GT:    true = !z && (n == v);
      C_LE:    true = z || (n != v);
      default: true = 1'b1;
    endcase
  end

endmodule

// File: rtl/zero_detect64.sv
// rtl/zero_detect64.sv - 64-bit all-zero detector
module zero_detect64 (
  input  logic [63:0] data,
  output logic        zero
);

  assign zero = ~|data;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - EX-stage branch resolution, fetch redirect handshake, NZCV flags, statistics
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [2:0]        ex_br_type,
  input  logic [3:0]        ex_cond,
  input  logic [DATA_W-1:0] ex_reg_data,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              ex_set_flags,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  input  logic              redirect_ready,
  output logic              flush,
  output logic [3:0]        flags,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  brc_state_t state, state_nxt;
  logic       accept, taken, is_branch, cond_ok, alu_zero, reg_zero;

  assign ex_ready       = (state == ST_RUN);
  assign accept         = ex_valid && ex_ready;
  assign redirect_valid = (state == ST_REDIRECT);
  assign flush          = (state != ST_RUN);

  zero_detect64 u_alu_zero (.data(64'(alu_result)),  .zero(alu_zero));
  zero_detect64 u_reg_zero (.data(64'(ex_reg_data)), .zero(reg_zero));

  // BCOND sees the flags before this instruction's own update lands
  cond_eval u_cond_eval (.cond(ex_cond), .nzcv(flags), .true(cond_ok));

  always_comb begin
    taken     = 1'b0;
    is_branch = 1'b1;
    case (ex_br_type)
      BR_B:     taken = 1'b1;
      BR_CBZ:   taken = reg_zero;
      BR_CBNZ:  taken = !reg_zero;
      BR_BCOND: taken = cond_ok;
      default:  is_branch = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:      if (accept && taken) state_nxt = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) state_nxt = ST_DRAIN;
      ST_DRAIN:    state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags       <= 4'b0000;
      redirect_pc <= '0;
      branch_cnt  <= '0;
      taken_cnt   <= '0;
    end else if (accept) begin
      if (ex_set_flags) flags <= {alu_result[DATA_W-1], alu_zero, alu_carry, alu_overflow};
      if (taken) redirect_pc <= ex_target;
      // counters stick at all-ones instead of wrapping
      if (is_branch && (branch_cnt != '1)) branch_cnt <= branch_cnt + CNT_W'(1);
      if (taken && (taken_cnt != '1)) taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_set_flags, alu_carry, alu_overflow;
  logic [2:0]  ex_br_type;
  logic [3:0]  ex_cond, flags;
  logic [63:0] ex_reg_data, ex_target, alu_result, redirect_pc;
  logic        redirect_valid, redirect_ready, flush;
  logic [15:0] branch_cnt, taken_cnt;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.DATA_W(64), .PC_W(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_br_type(ex_br_type), .ex_cond(ex_cond), .ex_reg_data(ex_reg_data),
    .ex_target(ex_target), .ex_set_flags(ex_set_flags), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush(flush), .flags(flags),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  typedef struct {
    logic [2:0]  br;
    logic [3:0]  cond;
    logic [63:0] reg_data;
    logic        sf;
    logic [63:0] alu;
    logic        c;
    logic        v;
    logic [63:0] tgt;
    logic        taken;
    logic [3:0]  flags_after;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [63:0] pc;
    logic [3:0]  flags;
    logic [15:0] bcnt;
    logic [15:0] tcnt;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sbq[$];
  vec_t        vecs[21];
  logic [15:0] m_bcnt, m_tcnt;
  logic [3:0]  m_flags;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  function automatic vec_t mk(input logic [2:0] br, input logic [3:0] cond, input logic [63:0] rd,
                              input logic sf, input logic [63:0] alu, input logic c, input logic v,
                              input logic [63:0] tgt, input logic tk, input logic [3:0] fl);
    vec_t r;
    r.br = br; r.cond = cond; r.reg_data = rd; r.sf = sf; r.alu = alu;
    r.c = c; r.v = v; r.tgt = tgt; r.taken = tk; r.flags_after = fl;
    return r;
  endfunction

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_br_type = 3'd0; ex_cond = 4'd0; ex_reg_data = '0;
    ex_target = '0; ex_set_flags = 1'b0; alu_result = '0; alu_carry = 1'b0; alu_overflow = 1'b0;
  endtask

  // drive one instruction, predict, then compare once the accept edge has passed
  task automatic issue(input vec_t v, input logic rdy);
    exp_t e, g;
    ex_valid = 1'b1; ex_br_type = v.br; ex_cond = v.cond; ex_reg_data = v.reg_data;
    ex_target = v.tgt; ex_set_flags = v.sf; alu_result = v.alu; alu_carry = v.c; alu_overflow = v.v;
    redirect_ready = rdy;
    if (v.br >= 3'd1 && v.br <= 3'd4) m_bcnt = sat_inc(m_bcnt);
    if (v.taken) m_tcnt = sat_inc(m_tcnt);
    m_flags = v.flags_after;
    e.taken = v.taken; e.pc = v.tgt; e.flags = m_flags; e.bcnt = m_bcnt; e.tcnt = m_tcnt;
    sbq.push_back(e);
    @(posedge clk); #1;
    idle_inputs();
    g = sbq.pop_front();
    check("flags", flags, g.flags);
    check("redirect_valid", redirect_valid, g.taken);
    check("flush", flush, g.taken);
    check("ex_ready", ex_ready, !g.taken);
    check("branch_cnt", branch_cnt, g.bcnt);
    check("taken_cnt", taken_cnt, g.tcnt);
    if (g.taken) check("redirect_pc", redirect_pc, g.pc);
  endtask

  task automatic finish_redirect();
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_redirect_valid", redirect_valid, 1'b0);
    check("drain_flush", flush, 1'b1);
    check("drain_ex_ready", ex_ready, 1'b0);
    @(posedge clk); #1;
    check("run_flush", flush, 1'b0);
    check("run_ex_ready", ex_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(3'd2, 4'd0,  64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'h100, 1'b1, 4'b0000);
    vecs[1]  = mk(3'd0, 4'd0,  64'd0,    1'b1, 64'd0, 1'b1, 1'b0, 64'h0,   1'b0, 4'b0110);
    vecs[2]  = mk(3'd4, 4'd0,  64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'h200, 1'b1, 4'b0110);
    vecs[3]  = mk(3'd4, 4'd1,  64'd0,    1'b1, 64'd5, 1'b0, 1'b0, 64'h250, 1'b0, 4'b0000);
    vecs[4]  = mk(3'd4, 4'd8,  64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'h260, 1'b0, 4'b0000);
    vecs[5]  = mk(3'd4, 4'd9,  64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'h300, 1'b1, 4'b0000);
    vecs[6]  = mk(3'd3, 4'd0,  64'h10,   1'b0, 64'd0, 1'b0, 1'b0, 64'h400, 1'b1, 4'b0000);
    vecs[7]  = mk(3'd3, 4'd0,  64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'h410, 1'b0, 4'b0000);
    vecs[8]  = mk(3'd2, 4'd0,  64'd1,    1'b0, 64'd0, 1'b0, 1'b0, 64'h420, 1'b0, 4'b0000);
    vecs[9]  = mk(3'd1, 4'd0,  64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'h500, 1'b1, 4'b0000);
    vecs[10] = mk(3'd0, 4'd0,  64'd0,    1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h0, 1'b0, 4'b1000);
    vecs[11] = mk(3'd4, 4'd11, 64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'h600, 1'b1, 4'b1000);
    vecs[12] = mk(3'd4, 4'd10, 64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'h610, 1'b0, 4'b1000);
    vecs[13] = mk(3'd4, 4'd4,  64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'h700, 1'b1, 4'b1000);
    vecs[14] = mk(3'd0, 4'd0,  64'd0,    1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 64'h0, 1'b0, 4'b1011);
    vecs[15] = mk(3'd4, 4'd12, 64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'h800, 1'b1, 4'b1011);
    vecs[16] = mk(3'd4, 4'd7,  64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'h810, 1'b0, 4'b1011);
    vecs[17] = mk(3'd4, 4'd15, 64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'h900, 1'b1, 4'b1011);
    vecs[18] = mk(3'd6, 4'd0,  64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'h910, 1'b0, 4'b1011);
    vecs[19] = mk(3'd4, 4'd13, 64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'h920, 1'b0, 4'b1011);
    vecs[20] = mk(3'd4, 4'd2,  64'd0,    1'b0, 64'd0, 1'b0, 1'b0, 64'hA00, 1'b1, 4'b1011);

    idle_inputs();
    redirect_ready = 1'b1;
    rst_n = 1'b0;
    m_bcnt = '0; m_tcnt = '0; m_flags = 4'b0000;
    #12;
    check("rst_ex_ready", ex_ready, 1'b1);
    check("rst_redirect_valid", redirect_valid, 1'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_flags", flags, 4'b0000);
    check("rst_redirect_pc", redirect_pc, 64'd0);
    check("rst_branch_cnt", branch_cnt, 16'd0);
    check("rst_taken_cnt", taken_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i], 1'b1);
      if (vecs[i].taken) finish_redirect();
    end

    // redirect stall: EX traffic during REDIRECT must be ignored
    issue(mk(3'd1, 4'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 64'hABC, 1'b1, m_flags), 1'b0);
    for (int k = 0; k < 5; k++) begin
      ex_valid = 1'b1; ex_br_type = 3'd1; ex_set_flags = 1'b1; ex_target = 64'h999;
      alu_result = 64'd0; alu_carry = 1'b1; alu_overflow = 1'b0;
      @(posedge clk); #1;
      check("stall_redirect_valid", redirect_valid, 1'b1);
      check("stall_redirect_pc", redirect_pc, 64'hABC);
      check("stall_flags", flags, m_flags);
      check("stall_branch_cnt", branch_cnt, m_bcnt);
      check("stall_taken_cnt", taken_cnt, m_tcnt);
    end
    idle_inputs();
    finish_redirect();

    // saturation from a preloaded taken count
    force dut.taken_cnt = 16'hFFFE;
    #1;
    release dut.taken_cnt;
    m_tcnt = 16'hFFFE;
    #1;
    check("preload_taken_cnt", taken_cnt, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      issue(mk(3'd1, 4'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 64'hC00 + 64'(k), 1'b1, m_flags), 1'b1);
      finish_redirect();
    end
    check("sat_taken_cnt", taken_cnt, 16'hFFFF);

    // asynchronous reset in the middle of a REDIRECT cycle
    issue(mk(3'd1, 4'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 64'hDEAD, 1'b1, m_flags), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_redirect_valid", redirect_valid, 1'b0);
    check("arst_flush", flush, 1'b0);
    check("arst_ex_ready", ex_ready, 1'b1);
    check("arst_branch_cnt", branch_cnt, 16'd0);
    check("arst_taken_cnt", taken_cnt, 16'd0);
    check("arst_flags", flags, 4'b0000);
    check("arst_redirect_pc", redirect_pc, 64'd0);
    m_bcnt = '0; m_tcnt = '0; m_flags = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ex_ready", ex_ready, 1'b1);
    issue(mk(3'd1, 4'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 64'h1234, 1'b1, 4'b0000), 1'b1);
    finish_redirect();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameters:
- DATA_W, 64, operand and ALU result width.
- PC_W, 64, branch target width.
- CNT_W, 16, statistics counter width.

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous, active-low reset.
- ex_valid, in, 1, instruction present in EX.
- ex_ready, out, 1, block accepts EX instruction; accept = ex_valid && ex_ready.
- ex_br_type, in, 3, 0 NONE, 1 B, 2 CBZ, 3 CBNZ, 4 BCOND; codes 5-7 are treated as NONE.
- ex_cond, in, 4, ARM condition code used by BCOND.
- ex_reg_data, in, DATA_W, register operand tested by CBZ/CBNZ.
- ex_target, in, PC_W, branch target address.
- ex_set_flags, in, 1, instruction updates the NZCV flags.
- alu_result, in, DATA_W, ALU output of the EX instruction.
- alu_carry, in, 1, ALU carry out.
- alu_overflow, in, 1, ALU overflow.
- redirect_valid, out, 1, fetch redirect request pending.
- redirect_pc, out, PC_W, redirect address.
- redirect_ready, in, 1, fetch accepts the redirect.
- flush, out, 1, squash IF/ID.
- flags, out, 4, registered NZCV, N in bit 3.
- branch_cnt, out, CNT_W, count of resolved branches.
- taken_cnt, out, CNT_W, count of taken branches.

Function
REQ-003 SHALL implement FSM states RUN, REDIRECT and DRAIN, with ex_ready = (state==RUN).
REQ-004 On accept in RUN, SHALL compute taken as follows:
- B: always taken.
- CBZ: ex_reg_data==0.
- CBNZ: ex_reg_data!=0.
- BCOND: cond_true(ex_cond, flags).
- NONE: never taken.
REQ-005 SHALL decode cond_true as follows:
- EQ Z, NE !Z, HS C, LO !C.
- MI N, PL !N, VS V, VC !V.
- HI C&!Z, LS !C|Z.
- GE N==V, LT N!=V.
- GT !Z&(N==V), LE Z|(N!=V).
- 1110/1111 always true.
REQ-006 Taken accept SHALL register redirect_pc<=ex_target and state<=REDIRECT on the next edge.
REQ-007 Not-taken accept and NONE SHALL leave the state at RUN.
REQ-008 In REDIRECT, redirect_valid and flush SHALL be 1, and redirect_pc SHALL be held stable.
REQ-009 In REDIRECT, redirect_ready=1 SHALL move the state to DRAIN; otherwise the state SHALL remain REDIRECT indefinitely.
REQ-010 DRAIN SHALL last exactly one cycle with flush=1 and redirect_valid=0, then return to RUN.
REQ-011 Taken-branch latency: resolve edge, then at least 1 REDIRECT cycle, then 1 DRAIN cycle; the minimum ex_ready-low span is 2 cycles.
REQ-012 On accept with ex_set_flags=1, flags SHALL load on the same edge:
- N = alu_result[DATA_W-1].
- Z = (alu_result==0).
- C = alu_carry.
- V = alu_overflow.
REQ-013 Flags SHALL be unchanged when ex_set_flags=0 or when there is no accept.
REQ-014 BCOND SHALL evaluate the pre-update flags; if ex_set_flags=1 on the same instruction, the flags still update afterwards.
REQ-015 branch_cnt SHALL increment on every accepted instruction with br_type in 1-4.
REQ-016 taken_cnt SHALL increment on every taken accept.
REQ-017 Both counters SHALL saturate at all-ones and never wrap.
REQ-018 Inputs with ex_valid=0, and all inputs outside RUN, SHALL be ignored (no flag, counter or state change).

Reset
REQ-019 rst_n=0 SHALL asynchronously force:
- state = RUN.
- flags = 0000.
- redirect_pc = 0.
- branch_cnt = 0, taken_cnt = 0.
REQ-020 During reset, redirect_valid and flush SHALL be 0 and ex_ready SHALL be 1.
REQ-021 Reset asserted in REDIRECT or DRAIN SHALL drop redirect_valid and flush immediately, without waiting for clk.
REQ-022 After rst_n rises, the first accept SHALL be possible on the next rising edge.

Structure
REQ-023 A shared package SHALL hold:
- br_type_t enum.
- cond_t enum of 4-bit codes.
- brc_state_t enum.
- DATA_W, PC_W and CNT_W defaults.
REQ-024 Condition decoding SHALL be a combinational sub-module cond_eval (inputs cond, NZCV; output true).
REQ-025 Both zero tests SHALL reuse the codebase's existing 64-bit zero-detect module, one instance each:
- alu_result (flag Z).
- ex_reg_data (CBZ/CBNZ).
REQ-026 Only flags, state, redirect_pc and the counters SHALL be registered.

Verification
REQ-027 SHALL cover these directed scenarios:
- Reset, then CBZ with ex_reg_data=0, target 0x100, redirect_ready=1 on the first REDIRECT cycle: redirect_valid high 1 cycle with redirect_pc=0x100; flush high 2 cycles; branch_cnt=1, taken_cnt=1.
- SUBS with alu_result=0xFFFF_FFFF_FFFF_FFFF and carry=0, then BCOND LT: flags=1000 and the branch is taken. Repeat with BCOND GE: not taken, ex_ready stays 1, taken_cnt unchanged.
- B with redirect_ready held low 5 cycles: redirect_valid and redirect_pc stable for 5 cycles; ex_valid pulses during the stall change neither the flags nor the counters.
- Preload taken_cnt to 0xFFFE, then 3 taken B: taken_cnt reads 0xFFFF and holds there.
- rst_n asserted mid-REDIRECT between edges: redirect_valid, flush and the counters go to 0 before the next clk edge; state is RUN after release.
- ex_br_type=6 with ex_valid=1: treated as NONE, no redirect, branch_cnt unchanged.
